uart_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter and sequencer that shares one uart_tx serializer between NUM_REQ on-chip requesters, e.g. the Hopfield state dump and the debug/status reporter.
- Each requester streams bytes with a valid/ack handshake and marks its final byte with a last flag.
- The arbiter locks onto a requester for a whole packet and optionally prefixes the packet with an ID header byte.
- It drives the serializer's i_Tx_DV and i_Tx_Byte, and watches its o_Tx_Active.

---
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that shares one UART serializer between NUM_REQ byte streams.
// Each packet is locked to one requester and can be preceded by an 8'hA0|id header byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter bit HEADER_EN    = 1'b1,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    output logic                 o_Busy,
    output logic                 o_Pkt_Done,
    output logic                 o_Abort
);

    localparam int         IDX_W    = $clog2(NUM_REQ);
    localparam int         CNT_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS + 1) : 1;
    localparam logic [7:0] HDR_BASE = 8'hA0;

    typedef enum logic [2:0] {
        IDLE,
        HDR_SEND,
        HDR_WAIT,
        DATA_SEND,
        DATA_WAIT
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   gidx, gidx_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [NUM_REQ-1:0] grant_d, ack_d;
    logic               tx_dv_d;
    logic [7:0]         tx_byte_d;
    logic               last, last_d;
    logic               loaded, loaded_d;
    logic               pkt_done_d, abort_d;
    logic [CNT_W-1:0]   stall, stall_d;
    logic               found;
    logic [IDX_W-1:0]   win;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Search starts just above the last owner, so the previous winner ranks lowest.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && i_Req[wrap_idx(ptr, i)]) begin
                found = 1'b1;
                win   = wrap_idx(ptr, i);
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d    = state;
        gidx_d     = gidx;
        ptr_d      = ptr;
        grant_d    = o_Grant;
        tx_dv_d    = o_Tx_DV;
        tx_byte_d  = o_Tx_Byte;
        last_d     = last;
        loaded_d   = loaded;
        stall_d    = stall;
        ack_d      = '0;
        pkt_done_d = 1'b0;
        abort_d    = 1'b0;

        case (state)
            IDLE: begin
                if (!i_Tx_Active && found) begin
                    gidx_d   = win;
                    grant_d  = NUM_REQ'(1) << win;
                    stall_d  = '0;
                    loaded_d = 1'b0;
                    if (HEADER_EN) begin
                        tx_byte_d = HDR_BASE | 8'(win);
                        tx_dv_d   = 1'b1;
                        state_d   = HDR_SEND;
                    end else begin
                        state_d = DATA_SEND;
                    end
                end
            end

            // DV stays up until the serializer reports active, covering its cleanup cycle.
            HDR_SEND: begin
                if (i_Tx_Active) begin
                    tx_dv_d = 1'b0;
                    state_d = HDR_WAIT;
                end
            end

            HDR_WAIT: begin
                if (!i_Tx_Active) state_d = DATA_SEND;
            end

            DATA_SEND: begin
                if (loaded) begin
                    if (i_Tx_Active) begin
                        tx_dv_d  = 1'b0;
                        loaded_d = 1'b0;
                        state_d  = DATA_WAIT;
                    end
                end else if (i_Req[gidx]) begin
                    tx_byte_d = i_Req_Byte[8*gidx +: 8];
                    last_d    = i_Req_Last[gidx];
                    ack_d     = NUM_REQ'(1) << gidx;
                    tx_dv_d   = 1'b1;
                    loaded_d  = 1'b1;
                    stall_d   = '0;
                end else if (TIMEOUT_CLKS != 0) begin
                    if (stall == CNT_W'(TIMEOUT_CLKS - 1)) begin
                        abort_d = 1'b1;
                        ptr_d   = gidx;
                        grant_d = '0;
                        stall_d = '0;
                        state_d = IDLE;
                    end else begin
                        stall_d = stall + 1'b1;
                    end
                end
            end

            DATA_WAIT: begin
                if (!i_Tx_Active) begin
                    if (last) begin
                        pkt_done_d = 1'b1;
                        ptr_d      = gidx;
                        grant_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        state_d = DATA_SEND;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            gidx       <= '0;
            ptr        <= IDX_W'(NUM_REQ - 1);
            o_Grant    <= '0;
            o_Ack      <= '0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= '0;
            last       <= 1'b0;
            loaded     <= 1'b0;
            stall      <= '0;
            o_Pkt_Done <= 1'b0;
            o_Abort    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            state      <= state_d;
            gidx       <= gidx_d;
            ptr        <= ptr_d;
            o_Grant    <= grant_d;
            o_Ack      <= ack_d;
            o_Tx_DV    <= tx_dv_d;
            o_Tx_Byte  <= tx_byte_d;
            last       <= last_d;
            loaded     <= loaded_d;
            stall      <= stall_d;
            o_Pkt_Done <= pkt_done_d;
            o_Abort    <= abort_d;
        end
    end

    assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: behavioural serializer (4 clocks/bit), line decoder and
// requester FIFOs; expected line bytes and owning grant are queued by the stimulus.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int TMO = 20;
    localparam int CPB = 4;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic [NR-1:0]   req      = '0;
    logic [8*NR-1:0] req_byte = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   ack, grant;
    logic            tx_dv;
    logic [7:0]      tx_byte;
    logic            tx_active = 1'b0;
    logic            busy, pkt_done, abort;
    logic            line = 1'b1;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .HEADER_EN(1'b1),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .i_Req(req),
        .i_Req_Byte(req_byte),
        .i_Req_Last(req_last),
        .o_Ack(ack),
        .o_Grant(grant),
        .o_Tx_DV(tx_dv),
        .o_Tx_Byte(tx_byte),
        .i_Tx_Active(tx_active),
        .o_Busy(busy),
        .o_Pkt_Done(pkt_done),
        .o_Abort(abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: byte expected on the line and the grant owning it when its stop bit is sampled.
    typedef struct packed {
        logic [7:0]    data;
        logic [NR-1:0] grant;
    } exp_t;
    exp_t exp_q[$];
    exp_t exp_e;

    task automatic push_exp(input logic [7:0] d, input logic [NR-1:0] g);
        exp_t e;
        e.data  = d;
        e.grant = g;
        exp_q.push_back(e);
    endtask

    // Per-requester byte FIFOs: stimulus appends, the driver pops on each ack.
    logic [8:0] rq_mem [NR][32];
    int         rq_head[NR] = '{default: 0};
    int         rq_tail[NR] = '{default: 0};

    task automatic queue_byte(input int k, input logic [7:0] d, input logic l);
        rq_mem[k][rq_tail[k]] = {l, d};
        rq_tail[k]++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) begin
                if (ack[k]) rq_head[k]++;
                if (rq_head[k] < rq_tail[k]) begin
                    req[k]           = 1'b1;
                    req_byte[8*k +: 8] = rq_mem[k][rq_head[k]][7:0];
                    req_last[k]      = rq_mem[k][rq_head[k]][8];
                end else begin
                    req[k]           = 1'b0;
                    req_byte[8*k +: 8] = 8'h00;
                    req_last[k]      = 1'b0;
                end
            end
        end
    end

    // Serializer model: ignores DV while busy and for one cleanup cycle after the stop bit.
    int         ser_phase = 0;
    int         ser_cnt   = 0;
    logic [9:0] ser_shift = '1;

    always @(posedge clk) begin
        case (ser_phase)
            0: if (tx_dv) begin
                ser_shift = {1'b1, tx_byte, 1'b0};
                ser_cnt   = 0;
                tx_active <= 1'b1;
                line      <= 1'b0;
                ser_phase = 1;
            end
            1: begin
                ser_cnt++;
                if (ser_cnt == 10 * CPB) begin
                    tx_active <= 1'b0;
                    line      <= 1'b1;
                    ser_phase = 2;
                end else begin
                    line <= ser_shift[ser_cnt / CPB];
                end
            end
            default: ser_phase = 0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: line decoder, frame spacing, ack ownership, pulse counters.
    int         rx_idx     = -1;
    logic [7:0] rx_data    = '0;
    int         last_start = 0;
    logic       gap_on     = 1'b0;
    logic       prev_on    = 1'b0;
    logic       act_prev   = 1'b0;
    int         fall_cyc   = 0;
    int         ack_tot[NR] = '{default: 0};
    int         done_tot   = 0;
    int         abort_tot  = 0;

    always @(negedge clk) begin
        if (act_prev && !tx_active) fall_cyc = cyc;
        act_prev = tx_active;

        if (rx_idx < 0) begin
            if (line == 1'b0) begin
                rx_idx = 0;
                if (gap_on && prev_on)
                    check("frame_gap_41_to_43", 32'((cyc - last_start >= 41) && (cyc - last_start <= 43)), 1);
                prev_on    = gap_on;
                last_start = cyc;
            end
        end else begin
            rx_idx++;
            if (rx_idx % CPB == 2) begin
                if (rx_idx / CPB >= 1 && rx_idx / CPB <= 8) begin
                    rx_data[rx_idx / CPB - 1] = line;
                end else if (rx_idx / CPB == 9) begin
                    check("stop_bit", 32'(line), 1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL frame_unexpected: got byte 0x%0h, expected no frame", rx_data);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("frame_byte", 32'(rx_data), 32'(exp_e.data));
                        check("frame_grant", 32'(grant), 32'(exp_e.grant));
                    end
                    rx_idx = -1;
                end
            end
        end

        if (ack != '0) begin
            check("ack_only_to_owner", 32'(ack & ~grant), 0);
            for (int k = 0; k < NR; k++) if (ack[k]) ack_tot[k]++;
        end
        if (pkt_done) done_tot++;
        if (abort) begin
            abort_tot++;
            check("abort_delay", 32'(cyc - fall_cyc), 32'(TMO + 1));
        end
    end

    task automatic wait_drain(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !tx_active) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        check(name, 32'(ok), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int ack_base[NR];
    int done_base, abort_base, dv_bad;
    bit seen;

    task automatic snap();
        for (int k = 0; k < NR; k++) ack_base[k] = ack_tot[k];
        done_base  = done_tot;
        abort_base = abort_tot;
    endtask

    task automatic check_acks(input string name, input int a0, input int a1, input int a2, input int a3);
        int exp_a[NR];
        exp_a = '{a0, a1, a2, a3};
        for (int k = 0; k < NR; k++)
            check($sformatf("%s_ack%0d", name, k), 32'(ack_tot[k] - ack_base[k]), 32'(exp_a[k]));
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({ack, grant, tx_dv, tx_byte, busy, pkt_done, abort}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single packet from requester 1 with header
        snap();
        push_exp(8'hA1, 4'b0010);
        push_exp(8'h55, 4'b0010);
        push_exp(8'h3C, 4'b0010);
        queue_byte(1, 8'h55, 1'b0);
        queue_byte(1, 8'h3C, 1'b1);
        wait_drain("single_drain", 500);
        check_acks("single", 0, 2, 0, 0);
        check("single_pkt_done", 32'(done_tot - done_base), 1);
        check("single_grant_idle", 32'(grant), 0);

        // Round-robin from reset: all requesters pending, requester 0 has two packets
        rst_n = 1'b0;
        snap();
        queue_byte(0, 8'h01, 1'b0); queue_byte(0, 8'h02, 1'b1);
        queue_byte(0, 8'h05, 1'b0); queue_byte(0, 8'h06, 1'b1);
        queue_byte(1, 8'h11, 1'b0); queue_byte(1, 8'h12, 1'b1);
        queue_byte(2, 8'h21, 1'b0); queue_byte(2, 8'h22, 1'b1);
        queue_byte(3, 8'h31, 1'b0); queue_byte(3, 8'h32, 1'b1);
        push_exp(8'hA0, 4'b0001); push_exp(8'h01, 4'b0001); push_exp(8'h02, 4'b0001);
        push_exp(8'hA1, 4'b0010); push_exp(8'h11, 4'b0010); push_exp(8'h12, 4'b0010);
        push_exp(8'hA2, 4'b0100); push_exp(8'h21, 4'b0100); push_exp(8'h22, 4'b0100);
        push_exp(8'hA3, 4'b1000); push_exp(8'h31, 4'b1000); push_exp(8'h32, 4'b1000);
        push_exp(8'hA0, 4'b0001); push_exp(8'h05, 4'b0001); push_exp(8'h06, 4'b0001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_drain("rr_drain", 2000);
        check_acks("rr", 4, 2, 2, 2);
        check("rr_pkt_done", 32'(done_tot - done_base), 5);

        // Back-to-back bytes: frames must follow each other within 3 spare clocks
        snap();
        gap_on = 1'b1;
        push_exp(8'hA1, 4'b0010);
        push_exp(8'h81, 4'b0010); push_exp(8'h42, 4'b0010); push_exp(8'h00, 4'b0010);
        push_exp(8'hFF, 4'b0010); push_exp(8'hA5, 4'b0010);
        queue_byte(1, 8'h81, 1'b0); queue_byte(1, 8'h42, 1'b0); queue_byte(1, 8'h00, 1'b0);
        queue_byte(1, 8'hFF, 1'b0); queue_byte(1, 8'hA5, 1'b1);
        wait_drain("b2b_drain", 1000);
        gap_on = 1'b0;
        check_acks("b2b", 0, 5, 0, 0);
        check("b2b_pkt_done", 32'(done_tot - done_base), 1);

        // Timeout: requester 2 stalls after a non-last byte; requester 3 then wins
        snap();
        queue_byte(2, 8'h11, 1'b0);
        queue_byte(3, 8'h33, 1'b1);
        queue_byte(0, 8'h44, 1'b1);
        push_exp(8'hA2, 4'b0100); push_exp(8'h11, 4'b0100);
        push_exp(8'hA3, 4'b1000); push_exp(8'h33, 4'b1000);
        push_exp(8'hA0, 4'b0001); push_exp(8'h44, 4'b0001);
        wait_drain("tmo_drain", 1500);
        check("tmo_abort_count", 32'(abort_tot - abort_base), 1);
        check("tmo_pkt_done", 32'(done_tot - done_base), 2);
        check_acks("tmo", 1, 0, 1, 1);

        // Reset during a data frame: packet lost, in-flight frame still completes on the line
        snap();
        queue_byte(0, 8'h77, 1'b0);
        queue_byte(0, 8'h88, 1'b1);
        push_exp(8'hA0, 4'b0001);
        push_exp(8'h77, 4'b0000);
        push_exp(8'hA0, 4'b0001);
        push_exp(8'h88, 4'b0001);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ack[0]) begin seen = 1'b1; break; end
        end
        check("rst_ack_seen", 32'(seen), 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_active) begin seen = 1'b1; break; end
        end
        check("rst_frame_started", 32'(seen), 1);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_async_outputs", 32'({ack, grant, tx_dv, tx_byte, busy, pkt_done, abort}), 0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        dv_bad = 0;
        for (int i = 0; i < 100 && tx_active; i++) begin
            @(negedge clk);
            if (tx_active && tx_dv) dv_bad++;
        end
        check("rst_no_dv_while_active", 32'(dv_bad), 0);
        wait_drain("rst_drain", 1000);
        check_acks("rst", 2, 0, 0, 0);
        check("rst_pkt_done", 32'(done_tot - done_base), 1);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
